// File: rtl/mdu_pkg.sv
// Shared MDUOp codes, default latencies and FSM encoding for the multiply/divide unit.
// MDU_MADD_EN adds the madd opcode to the set of multi-cycle operations.
`timescale 1ns/1ps
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'b0000;
  localparam logic [3:0] MDU_MULT  = 4'b0001;
  localparam logic [3:0] MDU_MULTU = 4'b0010;
  localparam logic [3:0] MDU_DIV   = 4'b0011;
  localparam logic [3:0] MDU_DIVU  = 4'b0100;
  localparam logic [3:0] MDU_MFHI  = 4'b0101;
  localparam logic [3:0] MDU_MFLO  = 4'b0110;
  localparam logic [3:0] MDU_MTHI  = 4'b0111;
  localparam logic [3:0] MDU_MTLO  = 4'b1000;
  localparam logic [3:0] MDU_MADD  = 4'b1001;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Opcodes that launch a multi-cycle operation when start is high.
  function automatic logic is_md_op(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the MDU: 64-bit products, quotient/remainder and div-by-zero flag.
// With MDU_MADD_EN the current HI/LO are taken in as the madd accumulate base.
`timescale 1ns/1ps
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_MADD_EN
  input  logic [31:0] hi,
  input  logic [31:0] lo,
`endif
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sgn;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] dvs_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Low 64 bits of a sign-extended product equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide goes through magnitudes so that -2^31 / -1 wraps cleanly.
  assign sgn      = (op == MDU_DIV);
  assign dvd      = (sgn && a[31]) ? (~a + 32'd1) : a;
  assign dvs      = (sgn && b[31]) ? (~b + 32'd1) : b;
  assign dvs_safe = (b == 32'd0) ? 32'd1 : dvs;
  assign q_mag    = dvd / dvs_safe;
  assign r_mag    = dvd % dvs_safe;
  assign quo      = (sgn && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
  assign rem      = (sgn && a[31]) ? (~r_mag + 32'd1) : r_mag;

  assign div0 = is_div_op(op) && (b == 32'd0);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        res_hi = rem;
        res_lo = quo;
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
`endif
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: HI/LO registers, mt/mf handling and the busy countdown.
// Build with MDU_MADD_EN to enable the madd (1001) multi-cycle accumulate.
`timescale 1ns/1ps
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUout
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e       state;
  mdu_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             launch;
  logic             commit;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_div0;
  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             arith_div0;

  mdu_arith u_arith (
    .op     (MDUOp),
    .a      (A),
    .b      (B),
`ifdef MDU_MADD_EN
    .hi     (HI),
    .lo     (LO),
`endif
    .res_hi (arith_hi),
    .res_lo (arith_lo),
    .div0   (arith_div0)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    launch    = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && is_md_op(MDUOp)) begin
          launch    = 1'b1;
          state_nxt = ST_RUN;
          cnt_nxt   = is_div_op(MDUOp) ? DIV_CNT : MULT_CNT;
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Results are captured at launch so later operand changes cannot disturb them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      HI        <= 32'd0;
      LO        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_div0 <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (launch) begin
        pend_hi   <= arith_hi;
        pend_lo   <= arith_lo;
        pend_div0 <= arith_div0;
      end
      if (commit) begin
        if (!pend_div0) begin
          HI <= pend_hi;
          LO <= pend_lo;
        end
      end else if (state == ST_IDLE && !start) begin
        if (MDUOp == MDU_MTHI) HI <= A;
        if (MDUOp == MDU_MTLO) LO <= A;
      end
    end
  end

  assign busy = (state == ST_RUN);

  always_comb begin
    MDUout = 32'd0;
    if (MDUOp == MDU_MFHI) MDUout = HI;
    else if (MDUOp == MDU_MFLO) MDUout = LO;
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed literal cases plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_mdu;
  import mdu_pkg::*;

  localparam int NMULT = 5;
  localparam int NDIV  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  int tests    = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state
  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
  bit          m_res_ok;
  int          m_left;

  mdu dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .MDUOp  (mdu_op),
    .A      (a_in),
    .B      (b_in),
    .busy   (busy),
    .HI     (hi),
    .LO     (lo),
    .MDUout (mdu_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit model_is_md(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
    if (op == 4'd9) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] h, input logic [31:0] l,
                               output logic [31:0] rh, output logic [31:0] rl, output bit ok);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ok = 1'b1;
    rh = 32'd0;
    rl = 32'd0;
    case (op)
      4'd1: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      4'd2: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      4'd3: begin
        if (b == 32'd0) ok = 1'b0;
        else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
      end
      4'd4: begin
        if (b == 32'd0) ok = 1'b0;
        else begin up = ua / ub; rl = up[31:0]; up = ua % ub; rh = up[31:0]; end
      end
      4'd9: begin p = longint'({h, l}) + sa * sb; rh = p[63:32]; rl = p[31:0]; end
      default: ok = 1'b0;
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_res_ok = 0; m_res_hi = 0; m_res_lo = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_res_ok) begin
        m_hi = m_res_hi;
        m_lo = m_res_lo;
      end
    end else if (start && model_is_md(mdu_op)) begin
      model_compute(mdu_op, a_in, b_in, m_hi, m_lo, m_res_hi, m_res_lo, m_res_ok);
      m_left = (mdu_op == 4'd3 || mdu_op == 4'd4) ? NDIV : NMULT;
    end else if (!start && mdu_op == 4'd7) begin
      m_hi = a_in;
    end else if (!start && mdu_op == 4'd8) begin
      m_lo = a_in;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
      check("model_mdu_out", mdu_out,
            (mdu_op == 4'd5) ? m_hi : (mdu_op == 4'd6) ? m_lo : 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #2;
    start  = st;
    mdu_op = op;
    a_in   = a;
    b_in   = b;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n_exp, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int n;
    drive(1'b1, op, a, b);
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
    wait_idle(n);
    check({name, "_busy_cycles"}, n, n_exp);
    check({name, "_hi"}, hi, hi_exp);
    check({name, "_lo"}, lo, lo_exp);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1; start = 1'b0; mdu_op = MDU_NONE; a_in = 0; b_in = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    run_op("mult",  MDU_MULT,  32'hFFFF_FFFF, 32'd2, NMULT, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, NMULT, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div",   MDU_DIV,   32'hFFFF_FFF9, 32'd2, NDIV,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  MDU_DIVU,  32'd7,         32'd2, NDIV,  32'd1,         32'd3);
    run_op("div0",  MDU_DIV,   32'd5,         32'd0, NDIV,  32'd1,         32'd3);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, NDIV, 32'd0, 32'h8000_0000);

    drive(1'b0, MDU_MTHI, 32'h1234_5678, 32'd0);
    drive(1'b0, MDU_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    check("mthi_mfhi", mdu_out, 32'h1234_5678);

    // mtlo arrives while the mult is running and must be dropped
    drive(1'b1, MDU_MULT, 32'd3, 32'd4);
    drive(1'b0, MDU_MTLO, 32'h0000_DEAD, 32'd0);
    drive(1'b0, MDU_MFLO, 32'd0, 32'd0);
    wait_idle(n);
    check("mtlo_busy_lo", lo, 32'h0000_000C);
    check("mtlo_busy_mflo", mdu_out, 32'h0000_000C);

    // reset in the third busy cycle of a mult aborts it
    drive(1'b1, MDU_MULT, 32'd5, 32'd6);
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (8) @(negedge clk);
    check("abort_no_late_lo", lo, 32'd0);

    drive(1'b1, 4'hF, 32'd1, 32'd1);
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
    @(negedge clk);
    check("unknown_op_busy", {31'd0, busy}, 32'd0);

`ifdef MDU_MADD_EN
    drive(1'b0, MDU_MTHI, 32'd0, 32'd0);
    drive(1'b0, MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
    run_op("madd", MDU_MADD, 32'd1, 32'd1, NMULT, 32'd1, 32'd0);
`else
    drive(1'b1, MDU_MADD, 32'd1, 32'd1);
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
    @(negedge clk);
    check("madd_off_busy", {31'd0, busy}, 32'd0);
    check("madd_off_lo", lo, 32'd0);
`endif

    // random traffic, checked every cycle by the model compare
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      reset  = ($urandom_range(0, 79) == 0);
      start  = ($urandom_range(0, 2) != 0);
      mdu_op = 4'($urandom_range(0, 15));
      a_in   = rand_operand();
      b_in   = rand_operand();
    end
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
    reset = 1'b0;
    wait_idle(n);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
